// File: rtl/rv_fifo_pkg.sv
// Shared constants and elaboration helpers for the extended ready/valid FIFO.
package rv_fifo_pkg;

  localparam int DEPTH_MIN = 2;

  // Width needed to hold every occupancy value 0..depth+out_reg.
  function automatic int cnt_width(input int depth, input int out_reg);
    return $clog2(depth + out_reg + 1);
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/rv_fifo_mem.sv
// 1-write/1-read register array with asynchronous read; storage is not reset.
module rv_fifo_mem
  import rv_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 16,
  localparam int AW = $clog2(DATA_DEPTH)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [AW-1:0]         waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]         raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rv_fifo_ext.sv
// Ready/valid FIFO with optional output register, programmable thresholds,
// synchronous flush and a sticky overflow flag.
module rv_fifo_ext
  import rv_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_DEPTH = 16,
  parameter int OUT_REG    = 0,
  localparam int CNT_W     = cnt_width(DATA_DEPTH, OUT_REG)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic                  ready_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_out,
  input  logic [CNT_W-1:0]      af_thresh,
  input  logic [CNT_W-1:0]      ae_thresh,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow
);

  localparam int AW  = $clog2(DATA_DEPTH);
  localparam int PW  = AW + 1;
  localparam int CAP = DATA_DEPTH + OUT_REG;

  if (!is_pow2(DATA_DEPTH) || DATA_DEPTH < DEPTH_MIN) begin : g_bad_depth
    $error("rv_fifo_ext: DATA_DEPTH must be a power of 2 and at least 2");
  end
  if (OUT_REG != 0 && OUT_REG != 1) begin : g_bad_oreg
    $error("rv_fifo_ext: OUT_REG must be 0 or 1");
  end

  // Handshake: a word moves on a rising edge where valid and ready are both
  // high on that side. ready_in depends only on registered count and flush,
  // never on ready_out, so a pop never opens space for a push in the same cycle.

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  ovf_q, ovf_d;
  logic                  push, pop, ram_rd, ram_empty;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign full         = (count_q == CNT_W'(CAP));
  assign empty        = (count_q == '0);
  assign ready_in     = !full && !flush;
  assign push         = valid_in && ready_in;
  assign pop          = valid_out && ready_out;
  assign ram_empty    = (wr_ptr_q == rd_ptr_q);
  assign count        = count_q;
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign overflow     = ovf_q;

  rv_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .DATA_DEPTH(DATA_DEPTH)
  ) u_mem (
    .clk    (clk),
    .we_i   (push),
    .waddr_i(wr_ptr_q[AW-1:0]),
    .wdata_i(data_in),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(ram_rdata)
  );

  if (OUT_REG != 0) begin : g_oreg
    logic                  ov_q, ov_d;
    logic [DATA_WIDTH-1:0] od_q, od_d;
    logic                  load;

    // Refill whenever the slot is free or being drained this cycle.
    assign load   = (!ov_q || pop) && !ram_empty;
    assign ram_rd = load;

    always_comb begin
      ov_d = ov_q;
      od_d = od_q;
      if (flush) begin
        ov_d = 1'b0;
      end else if (load) begin
        ov_d = 1'b1;
        od_d = ram_rdata;
      end else if (pop) begin
        ov_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        ov_q <= 1'b0;
        od_q <= '0;
      end else begin
        ov_q <= ov_d;
        od_q <= od_d;
      end
    end

    assign valid_out = ov_q;
    assign data_out  = od_q;
  end else begin : g_fwft
    // Without an output stage the RAM occupancy equals count, so !ram_empty == !empty.
    assign ram_rd    = pop;
    assign valid_out = !ram_empty;
    assign data_out  = ram_rdata;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push)   wr_ptr_d = wr_ptr_q + PW'(1);
      if (ram_rd) rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      if (valid_in && full) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule
